cache_way_ctrl: RTL and testbench
=================================

# cache_way_ctrl

Per-access way-management controller for the 4-way, 2048-set cache. It is the initiator that drives `cache_LRU`. It accepts one tag-lookup result at a time (hit/miss, hit way, per-way valid and dirty masks), then:
- reads the LRU state to pick a victim on a miss;
- sequences write-back and fill requests toward the memory side;
- updates the LRU with the way finally used, then reports completion.

## Interface
Parameters:
- SET_W, 11, set-index width (matches `cache_LRU` address width)
- WAYS, 4, associativity (fixed; WAY_W = 2)

Ports:
- main_clk  in  1  system clock
- main_reset  in  1  synchronous, active-high reset
- req_valid  in  1  lookup result valid
- req_ready  out  1  controller idle, can accept
- req_set  in  SET_W  set index
- req_hit  in  1  tag hit
- req_hit_way  in  2  hitting way (ignored on miss)
- req_valid_mask  in  4  per-way line-valid bits of the set
- req_dirty_mask  in  4  per-way dirty bits of the set
- lru_addr  out  SET_W  to `cache_LRU.addr`
- lru_used_index  out  2  to `cache_LRU.used_index`
- lru_enable_write  out  1  to `cache_LRU.enable_write`
- lru_least_used_index  in  2  from `cache_LRU.least_used_index`; valid one cycle after `lru_addr` is presented
- evict_valid / evict_ready  out / in  1 / 1  write-back request handshake
- evict_set, evict_way  out  SET_W, 2  write-back target
- fill_valid / fill_ready  out / in  1 / 1  line-fill request handshake
- fill_set, fill_way  out  SET_W, 2  fill target
- done_valid  out  1  one-cycle completion pulse
- done_way  out  2  way used by the completed access

## Operation
- States: IDLE, LRU_RD, VICTIM, EVICT, FILL, UPDATE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch set, hit, hit_way and masks; drive lru_addr=req_set.
  - Hit → UPDATE with way=hit_way. Miss → LRU_RD.
- LRU_RD: LRU read in flight; lru_enable_write=0.
- VICTIM: choose the way.
  - If valid_mask≠4'hF, way = lowest-index invalid way and the LRU output is ignored.
  - Otherwise way = lru_least_used_index, sampled this cycle.
  - Then: dirty_mask[way]=1 and valid_mask[way]=1 → EVICT; otherwise → FILL.
- EVICT: evict_valid=1 with set/way stable until evict_ready; on transfer → FILL.
- FILL: fill_valid=1 with set/way stable until fill_ready; on transfer → UPDATE.
- UPDATE:
  - lru_addr=latched set, lru_used_index=way, lru_enable_write=1 for exactly this one cycle → DONE.
  - `cache_LRU` performs its own read-modify-write internally.
- DONE: done_valid=1, done_way=way → IDLE.
- lru_addr holds the latched set from acceptance through UPDATE. Extra reads are harmless.
- lru_enable_write is never asserted outside UPDATE.

## Timing
- Registered outputs: all outputs except req_ready, which is decoded from state.
- Reset values: state IDLE; lru_addr=0, lru_used_index=0, lru_enable_write=0; evict_valid=0, fill_valid=0, done_valid=0; evict/fill/done payloads 0. req_ready=1 from the first cycle after reset deasserts.
- Hit: accept C0, UPDATE C1, done C2; next accept possible in C3.
- Clean miss, fill_ready tied high: accept C0, LRU_RD C1, VICTIM C2, FILL C3 (transfer), UPDATE C4, done C5.
- Dirty miss adds at least one EVICT cycle. fill_valid rises the cycle after the evict transfer, never in the same cycle.
- Valids drop the cycle after their transfer. Backpressure of any length is allowed; payload must not change while valid is held.
- Only one request is outstanding; req_valid while busy is ignored (req_ready=0).
- Reset mid-transaction: the access is abandoned. No LRU write, no done pulse, valids cleared on the next edge.

## Structure
- `cache_ctrl_pkg`: SET_W, WAY_W, WAYS constants and the state enum.
- Sub-module `cache_first_invalid_way`: a combinational 4→2 priority encoder plus an `any_invalid` flag.
- Single FSM in the top.

## Test plan
- Hit, set 0x005, way 2 → lru_enable_write=1 exactly in C1 with addr 0x005 and used 2; done_way=2 in C2; no evict/fill.
- Miss on set 0x010 after hits to ways 0,1,2,3 on 0x010, all valid and clean → fill_way=0, no evict_valid, LRU updated with 0, done_way=0.
- Same sequence with dirty_mask=4'b0001 → evict (0x010, 0), then fill (0x010, 0); evict_ready held low 5 cycles → payload stable, fill_valid waits.
- Miss with valid_mask=4'b1011 and dirty_mask=4'b1111 → way 2 chosen, no evict, LRU output ignored.
- Reset asserted during FILL → no lru_enable_write, no done_valid; fill_valid=0 next cycle; req_ready=1 after release.
- req_valid held through a busy dirty miss → second request accepted only in the cycle after done_valid.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared constants and FSM encoding for the 4-way cache way-management controller.
package cache_ctrl_pkg;

  localparam int SET_W = 11;
  localparam int WAY_W = 2;
  localparam int WAYS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LRU_RD = 3'd1,
    ST_VICTIM = 3'd2,
    ST_EVICT  = 3'd3,
    ST_FILL   = 3'd4,
    ST_UPDATE = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/cache_first_invalid_way.sv
// Priority encoder: lowest-index way whose valid bit is clear, plus a flag
// telling whether any such way exists.
module cache_first_invalid_way
  import cache_ctrl_pkg::*;
(
  input  logic [WAYS-1:0]  valid_mask,
  output logic [WAY_W-1:0] first_invalid,
  output logic             any_invalid
);

  // Scanning downward lets the lowest invalid index overwrite higher ones.
  always_comb begin
    first_invalid = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_mask[i]) first_invalid = WAY_W'(i);
    end
  end

  assign any_invalid = ~&valid_mask;

endmodule

// File: rtl/cache_way_ctrl.sv
// Per-access way controller: picks a victim on miss, sequences write-back and
// fill toward memory, updates cache_LRU with the way used, then signals done.
module cache_way_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int SET_W = cache_ctrl_pkg::SET_W,
  parameter int WAYS  = cache_ctrl_pkg::WAYS
) (
  input  logic             main_clk,
  input  logic             main_reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SET_W-1:0] req_set,
  input  logic             req_hit,
  input  logic [WAY_W-1:0] req_hit_way,
  input  logic [WAYS-1:0]  req_valid_mask,
  input  logic [WAYS-1:0]  req_dirty_mask,
  output logic [SET_W-1:0] lru_addr,
  output logic [WAY_W-1:0] lru_used_index,
  output logic             lru_enable_write,
  input  logic [WAY_W-1:0] lru_least_used_index,
  output logic             evict_valid,
  input  logic             evict_ready,
  output logic [SET_W-1:0] evict_set,
  output logic [WAY_W-1:0] evict_way,
  output logic             fill_valid,
  input  logic             fill_ready,
  output logic [SET_W-1:0] fill_set,
  output logic [WAY_W-1:0] fill_way,
  output logic             done_valid,
  output logic [WAY_W-1:0] done_way
);

  state_e state_q, state_d;

  logic [WAYS-1:0]  valid_mask_q, valid_mask_d;
  logic [WAYS-1:0]  dirty_mask_q, dirty_mask_d;
  logic [WAY_W-1:0] way_q, way_d;

  logic [SET_W-1:0] lru_addr_q, lru_addr_d;
  logic [WAY_W-1:0] lru_used_index_q, lru_used_index_d;
  logic             lru_enable_write_q, lru_enable_write_d;
  logic             evict_valid_q, evict_valid_d;
  logic [SET_W-1:0] evict_set_q, evict_set_d;
  logic [WAY_W-1:0] evict_way_q, evict_way_d;
  logic             fill_valid_q, fill_valid_d;
  logic [SET_W-1:0] fill_set_q, fill_set_d;
  logic [WAY_W-1:0] fill_way_q, fill_way_d;
  logic             done_valid_q, done_valid_d;
  logic [WAY_W-1:0] done_way_q, done_way_d;

  logic             accept;
  logic [WAY_W-1:0] first_invalid;
  logic             any_invalid;
  logic [WAY_W-1:0] victim_way;
  logic             victim_dirty;

  cache_first_invalid_way u_first_invalid (
    .valid_mask    (valid_mask_q),
    .first_invalid (first_invalid),
    .any_invalid   (any_invalid)
  );

  assign accept       = (state_q == ST_IDLE) && req_valid;
  // An invalid way is always preferred; the LRU answer only matters for a full set.
  assign victim_way   = any_invalid ? first_invalid : lru_least_used_index;
  assign victim_dirty = dirty_mask_q[victim_way] && valid_mask_q[victim_way];

  always_ff @(posedge main_clk) begin
    if (main_reset) begin
      state_q            <= ST_IDLE;
      valid_mask_q       <= '0;
      dirty_mask_q       <= '0;
      way_q              <= '0;
      lru_addr_q         <= '0;
      lru_used_index_q   <= '0;
      lru_enable_write_q <= 1'b0;
      evict_valid_q      <= 1'b0;
      evict_set_q        <= '0;
      evict_way_q        <= '0;
      fill_valid_q       <= 1'b0;
      fill_set_q         <= '0;
      fill_way_q         <= '0;
      done_valid_q       <= 1'b0;
      done_way_q         <= '0;
    end else begin
      state_q            <= state_d;
      valid_mask_q       <= valid_mask_d;
      dirty_mask_q       <= dirty_mask_d;
      way_q              <= way_d;
      lru_addr_q         <= lru_addr_d;
      lru_used_index_q   <= lru_used_index_d;
      lru_enable_write_q <= lru_enable_write_d;
      evict_valid_q      <= evict_valid_d;
      evict_set_q        <= evict_set_d;
      evict_way_q        <= evict_way_d;
      fill_valid_q       <= fill_valid_d;
      fill_set_q         <= fill_set_d;
      fill_way_q         <= fill_way_d;
      done_valid_q       <= done_valid_d;
      done_way_q         <= done_way_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = req_hit ? ST_UPDATE : ST_LRU_RD;
      ST_LRU_RD: state_d = ST_VICTIM;
      ST_VICTIM: state_d = victim_dirty ? ST_EVICT : ST_FILL;
      ST_EVICT:  if (evict_ready) state_d = ST_FILL;
      ST_FILL:   if (fill_ready) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so each strobe lines up
  // with the cycle its state is occupied; payloads load on entry and then hold.
  always_comb begin
    valid_mask_d     = valid_mask_q;
    dirty_mask_d     = dirty_mask_q;
    way_d            = way_q;
    lru_addr_d       = lru_addr_q;
    lru_used_index_d = lru_used_index_q;
    evict_set_d      = evict_set_q;
    evict_way_d      = evict_way_q;
    fill_set_d       = fill_set_q;
    fill_way_d       = fill_way_q;
    done_way_d       = done_way_q;

    if (accept) begin
      lru_addr_d   = req_set;
      valid_mask_d = req_valid_mask;
      dirty_mask_d = req_dirty_mask;
      way_d        = req_hit_way;
    end
    if (state_q == ST_VICTIM) way_d = victim_way;

    lru_enable_write_d = (state_d == ST_UPDATE);
    evict_valid_d      = (state_d == ST_EVICT);
    fill_valid_d       = (state_d == ST_FILL);
    done_valid_d       = (state_d == ST_DONE);

    if (state_d == ST_UPDATE) lru_used_index_d = way_d;
    if (state_d == ST_EVICT) begin
      evict_set_d = lru_addr_q;
      evict_way_d = way_d;
    end
    if (state_d == ST_FILL) begin
      fill_set_d = lru_addr_q;
      fill_way_d = way_d;
    end
    if (state_d == ST_DONE) done_way_d = way_d;
  end

  assign req_ready        = (state_q == ST_IDLE);
  assign lru_addr         = lru_addr_q;
  assign lru_used_index   = lru_used_index_q;
  assign lru_enable_write = lru_enable_write_q;
  assign evict_valid      = evict_valid_q;
  assign evict_set        = evict_set_q;
  assign evict_way        = evict_way_q;
  assign fill_valid       = fill_valid_q;
  assign fill_set         = fill_set_q;
  assign fill_way         = fill_way_q;
  assign done_valid       = done_valid_q;
  assign done_way         = done_way_q;

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Bench for cache_way_ctrl: a behavioural cache_LRU stand-in plus a per-set
// recency-list reference model predicting way, evict/fill and latencies.
module tb_cache_way_ctrl;

  logic        main_clk = 1'b0;
  logic        main_reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [10:0] req_set = '0;
  logic        req_hit = 1'b0;
  logic [1:0]  req_hit_way = '0;
  logic [3:0]  req_valid_mask = '0;
  logic [3:0]  req_dirty_mask = '0;
  logic [10:0] lru_addr;
  logic [1:0]  lru_used_index;
  logic        lru_enable_write;
  logic [1:0]  lru_least_used_index;
  logic        evict_valid;
  logic        evict_ready = 1'b0;
  logic [10:0] evict_set;
  logic [1:0]  evict_way;
  logic        fill_valid;
  logic        fill_ready = 1'b0;
  logic [10:0] fill_set;
  logic [1:0]  fill_way;
  logic        done_valid;
  logic [1:0]  done_way;

  int checks = 0;
  int errors = 0;

  // Recency lists per set: index 0 is the least recently used way.
  logic [1:0] stub_list [0:2047][0:3];
  logic [1:0] ref_list  [0:2047][0:3];

  always #5 main_clk = ~main_clk;

  cache_way_ctrl dut (
    .main_clk             (main_clk),
    .main_reset           (main_reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_set              (req_set),
    .req_hit              (req_hit),
    .req_hit_way          (req_hit_way),
    .req_valid_mask       (req_valid_mask),
    .req_dirty_mask       (req_dirty_mask),
    .lru_addr             (lru_addr),
    .lru_used_index       (lru_used_index),
    .lru_enable_write     (lru_enable_write),
    .lru_least_used_index (lru_least_used_index),
    .evict_valid          (evict_valid),
    .evict_ready          (evict_ready),
    .evict_set            (evict_set),
    .evict_way            (evict_way),
    .fill_valid           (fill_valid),
    .fill_ready           (fill_ready),
    .fill_set             (fill_set),
    .fill_way             (fill_way),
    .done_valid           (done_valid),
    .done_way             (done_way)
  );

  // cache_LRU stand-in: registered read, internal read-modify-write on update.
  always @(posedge main_clk) begin : lru_stub
    int p;
    lru_least_used_index <= stub_list[lru_addr][0];
    if (lru_enable_write === 1'b1) begin
      p = 0;
      for (int i = 0; i < 4; i++) if (stub_list[lru_addr][i] == lru_used_index) p = i;
      for (int i = 0; i < 3; i++) if (i >= p) stub_list[lru_addr][i] = stub_list[lru_addr][i + 1];
      stub_list[lru_addr][3] = lru_used_index;
    end
  end

  task automatic issue(input logic [10:0] s, input logic h, input logic [1:0] hw,
                       input logic [3:0] vm, input logic [3:0] dm);
    int k = 0;
    while (req_ready !== 1'b1 && k < 50) begin
      @(posedge main_clk); #1; k++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL issue_ready: req_ready=%b expected 1", req_ready);
    end
    req_set = s; req_hit = h; req_hit_way = hw;
    req_valid_mask = vm; req_dirty_mask = dm; req_valid = 1'b1;
    @(posedge main_clk); #1;
    req_valid = 1'b0;
  endtask

  // Called in the first cycle after acceptance; follows the access to done.
  task automatic check_txn(input logic [10:0] s, input logic h, input logic [1:0] hw,
                           input logic [3:0] vm, input logic [3:0] dm,
                           input int ev_stall, input int fl_stall, input string tag);
    logic [1:0] ew;
    logic       found, exp_ev, fin, ev_seen, fl_seen;
    int         exp_done, c, wr, ev_cnt, fl_cnt, p;
    found = 1'b0; ew = '0;
    if (h) ew = hw;
    else begin
      for (int i = 0; i < 4; i++) if (!vm[i] && !found) begin ew = 2'(i); found = 1'b1; end
      if (!found) ew = ref_list[s][0];
    end
    exp_ev   = !h && dm[ew] && vm[ew];
    exp_done = h ? 2 : 5 + (exp_ev ? ev_stall + 1 : 0) + fl_stall;
    c = 1; wr = 0; ev_cnt = 0; fl_cnt = 0; fin = 0; ev_seen = 0; fl_seen = 0;
    while (!fin && c <= 400) begin
      if (done_valid !== 1'b1) begin
        checks++;
        if (lru_addr !== s) begin
          errors++; $display("FAIL %s lru_addr c%0d: got %h expected %h", tag, c, lru_addr, s);
        end
        checks++;
        if (req_ready !== 1'b0) begin
          errors++; $display("FAIL %s busy_ready c%0d: got %b expected 0", tag, c, req_ready);
        end
      end
      if (lru_enable_write === 1'b1) begin
        wr++;
        checks++;
        if (c != exp_done - 1 || lru_used_index !== ew) begin
          errors++;
          $display("FAIL %s lru_write: cycle %0d used %0d, expected cycle %0d used %0d",
                   tag, c, lru_used_index, exp_done - 1, ew);
        end
      end
      if (evict_valid === 1'b1) begin
        ev_seen = 1;
        checks++;
        if (evict_set !== s || evict_way !== ew || fill_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s evict: set %h way %0d fill_valid %b, expected set %h way %0d fill_valid 0",
                   tag, evict_set, evict_way, fill_valid, s, ew);
        end
        evict_ready = (ev_cnt >= ev_stall);
        ev_cnt++;
      end else evict_ready = 1'b0;
      if (fill_valid === 1'b1) begin
        fl_seen = 1;
        checks++;
        if (fill_set !== s || fill_way !== ew || (exp_ev && ev_cnt <= ev_stall)) begin
          errors++;
          $display("FAIL %s fill: set %h way %0d after %0d evict cycles, expected set %h way %0d",
                   tag, fill_set, fill_way, ev_cnt, s, ew);
        end
        fill_ready = (fl_cnt >= fl_stall);
        fl_cnt++;
      end else fill_ready = 1'b0;
      if (done_valid === 1'b1) begin
        fin = 1;
        checks++;
        if (done_way !== ew || c != exp_done) begin
          errors++;
          $display("FAIL %s done: way %0d at cycle %0d, expected way %0d at cycle %0d",
                   tag, done_way, c, ew, exp_done);
        end
      end
      if (!fin) begin
        @(posedge main_clk); #1; c++;
      end
    end
    evict_ready = 1'b0; fill_ready = 1'b0;
    checks++;
    if (!fin) begin
      errors++; $display("FAIL %s timeout: no done_valid within %0d cycles", tag, c);
    end
    checks++;
    if (wr != 1 || ev_seen != exp_ev || fl_seen != !h) begin
      errors++;
      $display("FAIL %s counts: writes %0d evict %b fill %b, expected writes 1 evict %b fill %b",
               tag, wr, ev_seen, fl_seen, exp_ev, !h);
    end
    checks++;
    if (ev_cnt != (exp_ev ? ev_stall + 1 : 0) || fl_cnt != (h ? 0 : fl_stall + 1)) begin
      errors++;
      $display("FAIL %s valid_len: evict %0d fill %0d cycles, expected %0d and %0d", tag,
               ev_cnt, fl_cnt, exp_ev ? ev_stall + 1 : 0, h ? 0 : fl_stall + 1);
    end
    if (fin) begin
      p = 0;
      for (int i = 0; i < 4; i++) if (ref_list[s][i] == ew) p = i;
      for (int i = 0; i < 3; i++) if (i >= p) ref_list[s][i] = ref_list[s][i + 1];
      ref_list[s][3] = ew;
    end
  endtask

  task automatic run(input logic [10:0] s, input logic h, input logic [1:0] hw,
                     input logic [3:0] vm, input logic [3:0] dm,
                     input int ev_stall, input int fl_stall, input string tag);
    issue(s, h, hw, vm, dm);
    check_txn(s, h, hw, vm, dm, ev_stall, fl_stall, tag);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge main_clk);
    #1;
    checks++;
    if ({lru_addr, lru_used_index, lru_enable_write, evict_valid, evict_set, evict_way,
         fill_valid, fill_set, fill_way, done_valid, done_way} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: lru_addr %h used %0d we %b ev %b fv %b dv %b, expected all 0",
               lru_addr, lru_used_index, lru_enable_write, evict_valid, fill_valid, done_valid);
    end
    main_reset = 1'b0;
    @(posedge main_clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_hit();
    run(11'h005, 1'b1, 2'd2, 4'hF, 4'h0, 0, 0, "hit");
  endtask

  task automatic test_clean_miss();
    for (int w = 0; w < 4; w++) run(11'h010, 1'b1, 2'(w), 4'hF, 4'h0, 0, 0, "warm_clean");
    run(11'h010, 1'b0, 2'd3, 4'hF, 4'h0, 0, 0, "clean_miss");
  endtask

  task automatic test_dirty_miss();
    for (int w = 0; w < 4; w++) run(11'h010, 1'b1, 2'(w), 4'hF, 4'h0, 0, 0, "warm_dirty");
    run(11'h010, 1'b0, 2'd3, 4'hF, 4'b0001, 5, 0, "dirty_miss");
  endtask

  task automatic test_invalid_way();
    run(11'h020, 1'b0, 2'd0, 4'b1011, 4'b1111, 0, 0, "invalid_way");
  endtask

  task automatic test_reset_mid_fill();
    int k = 0;
    issue(11'h040, 1'b0, 2'd0, 4'hF, 4'h0);
    while (fill_valid !== 1'b1 && k < 20) begin
      @(posedge main_clk); #1; k++;
    end
    checks++;
    if (fill_valid !== 1'b1) begin
      errors++; $display("FAIL rst_fill_reach: fill_valid=%b expected 1", fill_valid);
    end
    main_reset = 1'b1;
    @(posedge main_clk); #1;
    checks++;
    if ({fill_valid, evict_valid, done_valid, lru_enable_write} !== 4'b0 || lru_addr !== '0) begin
      errors++;
      $display("FAIL rst_fill_clear: fv %b ev %b dv %b we %b addr %h, expected all 0",
               fill_valid, evict_valid, done_valid, lru_enable_write, lru_addr);
    end
    main_reset = 1'b0;
    @(posedge main_clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_fill_ready: got %b expected 1", req_ready);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({lru_enable_write, done_valid, fill_valid} !== 3'b0) begin
        errors++;
        $display("FAIL rst_fill_quiet: we %b dv %b fv %b expected 0", lru_enable_write, done_valid, fill_valid);
      end
      @(posedge main_clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    issue(11'h030, 1'b0, 2'd0, 4'hF, 4'hF);
    req_set = 11'h031; req_hit = 1'b1; req_hit_way = 2'd1;
    req_valid_mask = 4'hF; req_dirty_mask = 4'h0; req_valid = 1'b1;
    check_txn(11'h030, 1'b0, 2'd0, 4'hF, 4'hF, 2, 1, "b2b_first");
    @(posedge main_clk); #1;
    checks++;
    if (req_ready !== 1'b1 || lru_enable_write !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: ready %b we %b, expected ready 1 we 0", req_ready, lru_enable_write);
    end
    @(posedge main_clk); #1;
    req_valid = 1'b0;
    check_txn(11'h031, 1'b1, 2'd1, 4'hF, 4'h0, 0, 0, "b2b_second");
  endtask

  task automatic test_random();
    logic [10:0] s;
    logic        h;
    logic [1:0]  hw;
    logic [3:0]  vm, dm;
    for (int n = 0; n < 60; n++) begin
      s  = ($urandom_range(0, 9) == 0) ? 11'h7FF : 11'($urandom_range(0, 7));
      h  = 1'($urandom_range(0, 1));
      hw = 2'($urandom_range(0, 3));
      vm = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      dm = 4'($urandom_range(0, 15));
      run(s, h, hw, vm, dm, $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    for (int s = 0; s < 2048; s++)
      for (int i = 0; i < 4; i++) begin
        stub_list[s][i] = 2'(i);
        ref_list[s][i]  = 2'(i);
      end
    test_reset();
    test_hit();
    test_clean_miss();
    test_dirty_miss();
    test_invalid_way();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
